// File: rtl/sdf_r2_stage.sv
// rtl/sdf_r2_stage.sv - radix-2 single-path delay-feedback DIF stage with realignment and drain
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   valid_i, sof_i, flush_i   sample valid, frame start, drain request (zero-sample beat when valid_i low)
//   data_in_r, data_in_i      DATA_W-bit two's-complement input sample
//   valid_o, sof_o, err_o     output valid, first output of a frame, misaligned frame-start pulse
//   data_out_r, data_out_i    OUT_W-bit two's-complement output sample
module sdf_r2_stage #(
    parameter int DATA_W = 15,
    parameter int DEPTH  = 4,
    parameter int TW_MJ  = 0,
    parameter int SCALE  = 0,
    parameter int OUT_W  = DATA_W + 1 - SCALE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              sof_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_in_r,
    input  logic [DATA_W-1:0] data_in_i,
    output logic              valid_o,
    output logic              sof_o,
    output logic              err_o,
    output logic [OUT_W-1:0]  data_out_r,
    output logic [OUT_W-1:0]  data_out_i
);

    localparam int SW = DATA_W + 1;
    localparam int CW = $clog2(2 * DEPTH);
    localparam logic [CW-1:0] C_HALF = CW'(DEPTH);
    localparam logic [CW-1:0] C_HM1  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] C_LAST = CW'(2 * DEPTH - 1);
    localparam logic [CW-1:0] C_ROT  = CW'(DEPTH + DEPTH / 2);
    // With a single-entry delay line there is no second quarter to rotate.
    localparam bit ROT_EN = (TW_MJ != 0) && (DEPTH > 1);

    logic              in_valid, in_sof, in_flush;
    logic [DATA_W-1:0] in_r, in_i;

    logic [CW-1:0]     cnt;
    logic              fill, diff_ok;
    logic [SW-1:0]     dl_r [DEPTH];
    logic [SW-1:0]     dl_i [DEPTH];

    logic              realign, misalign, flush_adv, adv, phase1, rot;
    logic              fill_eff, dok_eff;
    logic [CW-1:0]     c_eff;
    logic [SW-1:0]     x_r, x_i, sum_r, sum_i, dif_r, dif_i;
    logic [SW-1:0]     st_r, st_i, pre_r, pre_i;
    logic [OUT_W-1:0]  nxt_r, nxt_i;

    always_comb begin
        realign   = in_valid & in_sof;
        misalign  = realign & (cnt != '0);
        c_eff     = realign ? '0 : cnt;
        fill_eff  = fill & ~misalign;
        dok_eff   = diff_ok & ~misalign;
        // A drain beat only advances while previous-frame differences remain to be emitted.
        flush_adv = ~in_valid & in_flush & (cnt < C_HALF) & diff_ok;
        adv       = in_valid | flush_adv;
        phase1    = (c_eff >= C_HALF);

        x_r   = in_valid ? {in_r[DATA_W-1], in_r} : '0;
        x_i   = in_valid ? {in_i[DATA_W-1], in_i} : '0;
        sum_r = dl_r[0] + x_r;
        sum_i = dl_i[0] + x_i;
        dif_r = dl_r[0] - x_r;
        dif_i = dl_i[0] - x_i;

        rot = ROT_EN && phase1 && (c_eff >= C_ROT);

        st_r = x_r;
        st_i = x_i;
        if (phase1) begin
            if (rot) begin
                // Multiply by -j: (re, im) -> (im, -re).
                st_r = dif_i;
                st_i = -dif_r;
            end else begin
                st_r = dif_r;
                st_i = dif_i;
            end
        end

        pre_r = phase1 ? sum_r : dl_r[0];
        pre_i = phase1 ? sum_i : dl_i[0];
    end

    generate
        if (SCALE != 0) begin : g_scale
            // Round half up: add one, then drop the LSB as an arithmetic shift.
            logic [SW:0] rnd_r, rnd_i;
            logic        unused_rnd;
            assign rnd_r      = {pre_r[SW-1], pre_r} + {{SW{1'b0}}, 1'b1};
            assign rnd_i      = {pre_i[SW-1], pre_i} + {{SW{1'b0}}, 1'b1};
            assign nxt_r      = rnd_r[OUT_W:1];
            assign nxt_i      = rnd_i[OUT_W:1];
            assign unused_rnd = ^{rnd_r[SW], rnd_r[0], rnd_i[SW], rnd_i[0]};
        end else begin : g_full
            assign nxt_r = pre_r;
            assign nxt_i = pre_i;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_valid   <= 1'b0;
            in_sof     <= 1'b0;
            in_flush   <= 1'b0;
            in_r       <= '0;
            in_i       <= '0;
            cnt        <= '0;
            fill       <= 1'b0;
            diff_ok    <= 1'b0;
            valid_o    <= 1'b0;
            sof_o      <= 1'b0;
            err_o      <= 1'b0;
            data_out_r <= '0;
            data_out_i <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dl_r[k] <= '0;
                dl_i[k] <= '0;
            end
        end else begin
            in_valid <= valid_i;
            in_sof   <= sof_i;
            in_flush <= flush_i;
            in_r     <= data_in_r;
            in_i     <= data_in_i;

            valid_o <= adv & (phase1 ? fill_eff : dok_eff);
            sof_o   <= adv & phase1 & fill_eff & (c_eff == C_HALF);
            err_o   <= misalign;

            if (adv) begin
                data_out_r <= nxt_r;
                data_out_i <= nxt_i;
                for (int k = 0; k < DEPTH - 1; k++) begin
                    dl_r[k] <= dl_r[k+1];
                    dl_i[k] <= dl_i[k+1];
                end
                dl_r[DEPTH-1] <= st_r;
                dl_i[DEPTH-1] <= st_i;

                if (flush_adv && (c_eff == C_HM1)) begin
                    // Last pending difference drained: return to an idle-clean frame start.
                    cnt     <= '0;
                    fill    <= 1'b0;
                    diff_ok <= 1'b0;
                end else if (c_eff == C_LAST) begin
                    cnt     <= '0;
                    fill    <= 1'b0;
                    diff_ok <= dok_eff | fill_eff;
                end else begin
                    cnt     <= c_eff + CW'(1);
                    fill    <= fill_eff | (c_eff == C_HM1);
                    diff_ok <= dok_eff;
                end
            end
        end
    end

endmodule

// File: doc/sdf_r2_stage.md
# sdf_r2_stage

Parametrised radix-2 single-path delay-feedback (R2SDF) DIF stage for the pipelined FFT datapath. It replaces the fixed-depth per-stage wrappers with one block that can be instantiated at every stage:
- configurable data width, feedback depth, optional trivial −j twiddle (R2² odd stage) and optional ÷2 scaling;
- frame-start realignment, a stall-tolerant valid stream and a drain (flush) mechanism.

It sits between consecutive twiddle/stage blocks in the streaming FFT chain.

## Interface
- DATA_W, 15, input component width (signed)
- DEPTH, 4, feedback delay length D (power of 2, ≥1); frame length 2D
- TW_MJ, 0, 1: multiply difference samples with index j ≥ D/2 by −j (ignored when D=1)
- SCALE, 0, 1: outputs divided by 2 with round-half-up, width DATA_W; 0: width DATA_W+1
- OUT_W, DATA_W+1−SCALE, derived output width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- valid_i  in  1  input sample valid
- sof_i  in  1  first sample of a frame (qualified by valid_i)
- flush_i  in  1  drain request, zero-sample beat when valid_i low
- data_in_r / data_in_i  in  DATA_W  signed input sample
- valid_o  out  1  output sample valid
- sof_o  out  1  first output sample of a frame
- err_o  out  1  one-cycle pulse: sof_i received while counter ≠ 0
- data_out_r / data_out_i  out  OUT_W  signed output sample

## Operation
- All inputs registered once (valid_i, sof_i, flush_i, data). All logic below acts on registered copies.
- Advance: registered valid_i=1, or registered flush_i=1 with valid_i=0 and c<D and diff_ok=1. Otherwise nothing changes (stall).
- Counter c, 0..2D−1, increments per advance and wraps.
- Delay line: D entries of (DATA_W+1)-bit complex words, shifting one entry per advance.
- Phase 0 (c<D):
  - input, sign-extended, enters the delay line;
  - delay-line head goes to the output (difference of previous frame).
- Phase 1 (c≥D):
  - output = head + in;
  - delay-line input = head − in;
  - with TW_MJ=1 and (c−D) ≥ D/2, the stored word is (im, −re), i.e. ×(−j);
  - no overflow is possible at DATA_W+1 bits.
- Scaling: SCALE=1 gives out = (v+1)>>>1, arithmetic shift, applied to sums and differences at output.
- Flags:
  - fill: set on the advance with c=D−1; cleared on wrap.
  - diff_ok: set on the wrap 2D−1→0 while fill=1.
- valid_o is asserted for:
  - phase-1 advances with fill=1;
  - phase-0 advances with diff_ok=1.
- sof_o asserts with the output of the advance at c=D when fill=1.
- sof realignment: registered valid_i & sof_i forces c to 0 for that sample.
  - If c≠0 beforehand: err_o pulses, fill and diff_ok clear, and no phase-0 output is produced for this frame.
  - If c=0: no error, normal operation.
- Drain: flush advances insert zero input. When a flush advance reaches c=D, the block forces c=0 and clears fill and diff_ok. Net effect: D flush beats emit the last D differences, then the block is idle-clean.
- flush_i with valid_i=1 is ignored (real data wins).
- Reset: c=0, fill=0, diff_ok=0, delay line zero, all outputs 0.
- Mid-frame reset: everything returns to reset state immediately. The first post-reset frame behaves as after power-up.

## Timing
- Latency: an input accepted at port edge t gives its advance result registered at t+2. valid_o, sof_o, err_o and data share that alignment.
- Stream latency is D samples: a sample's contributions appear D (sum) or 2D (difference) advances later.
- Throughput: one sample per clock; arbitrary valid_i gaps allowed, and the state is frozen during gaps.
- First output after reset: the advance at c=D of the first frame (D samples with no valid_o before it).
- Back-to-back frames: continuous valid_o after the first D samples, no bubbles.

## Test plan
- **D=2, SCALE=0, TW_MJ=0 (real inputs).**
  - Stimulus: frame 1,2,3,4 with sof on sample 1, then 2 flush beats.
  - Required: outputs 4,6,−2,−2; sof_o on the 4; valid_o low for the first 2 samples.
- **D=2, TW_MJ=1, same frame.**
  - Required: outputs 4, 6, −2+0j, 0+2j.
- **D=4, DATA_W=15, SCALE=1, back-to-back frames.**
  - Stimulus: two frames of all 16383, then a frame of all −16384.
  - Required: sums 16383 (32766>>1 rounded); differences 0; last-frame sums −16384; no gaps in valid_o.
- **Stall.**
  - Stimulus: repeat the first test with valid_i low every other cycle.
  - Required: identical output sequence; valid_o only on the advance cycles, at t+2.
- **Misaligned sof.**
  - Stimulus: D=4; sof_i on sample 3 of a frame.
  - Required: err_o pulses once; the next 4 advances give no valid_o; the following sums are correct for the realigned frame.
- **Reset mid-frame.**
  - Stimulus: assert rst after 5 samples, then release.
  - Required: all outputs 0 during reset; the post-reset frame matches the golden FFT stage model.
